// File: rtl/regs_out_port.sv
// OUT-instruction output port: samples register-bank entries on OUT/OUTP
// instructions and queues them in a first-word-fall-through FIFO that
// drains over a valid/ready bus.
module regs_out_port #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned REGSIZE  = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [REGSIZE-1:0]        reg0,
    input  logic [REGSIZE-1:0]        reg1,
    output logic [DATASIZE-1:0]       data_out,
    output logic                      out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [2:0] OpOut  = 3'b111;
    localparam logic [2:0] OpOutp = 3'b101;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StPair2 = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [REGSIZE-1:0] hold_q, hold_d;
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q, count_d;

    logic [REGSIZE-1:0] mem_data_q [DEPTH];
    logic               mem_sel_q  [DEPTH];

    logic               not_full;
    logic               accept;
    logic               pop;
    logic               push;
    logic               push_sel;
    logic [REGSIZE-1:0] push_data;

    assign not_full    = count_q < CntW'(DEPTH);
    assign instr_ready = (state_q == StIdle) && not_full;
    assign accept      = instr_valid && instr_ready;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign count       = count_q;

    // Head is masked while empty so the bus reads zero after reset.
    assign data_out = out_valid ? DATASIZE'(mem_data_q[rd_ptr_q]) : '0;
    assign out_sel  = out_valid ? mem_sel_q[rd_ptr_q] : 1'b0;

    // Instruction decode and pair sequencing; selects the push source.
    always_comb begin
        push      = 1'b0;
        push_sel  = 1'b0;
        push_data = '0;
        state_d   = state_q;
        hold_d    = hold_q;
        if (state_q == StIdle) begin
            if (accept) begin
                if (instr[7:5] == OpOut) begin
                    push      = 1'b1;
                    push_sel  = instr[0];
                    push_data = instr[0] ? reg1 : reg0;
                end else if (instr[7:5] == OpOutp) begin
                    push      = 1'b1;
                    push_sel  = 1'b0;
                    push_data = reg0;
                    hold_d    = reg1;
                    state_d   = StPair2;
                end
            end
        end else begin
            // A same-cycle pop frees the slot this beat lands in.
            if (not_full || pop) begin
                push      = 1'b1;
                push_sel  = 1'b1;
                push_data = hold_q;
                state_d   = StIdle;
            end
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop cancel.
    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, hold register, pointers and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_sel_q[wr_ptr_q]  <= push_sel;
        end
    end

endmodule

// File: tb/tb_regs_out_port.sv
// Directed bench for regs_out_port: one task per scenario, inline checks.
module tb_regs_out_port;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] reg0;
    logic [3:0] reg1;
    logic [7:0] data_out;
    logic       out_sel;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;

    int checks;
    int errors;

    regs_out_port #(
        .DATASIZE (8),
        .REGSIZE  (4),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .reg0        (reg0),
        .reg1        (reg1),
        .data_out    (data_out),
        .out_sel     (out_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; instr = 8'h00; instr_valid = 1'b0;
        reg0 = 4'h0; reg1 = 4'h0; out_ready = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 8'h00 || out_sel !== 1'b0 ||
            instr_ready !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h sel=%b ready=%b count=%0d required 0 00 0 1 0",
                     out_valid, data_out, out_sel, instr_ready, count);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_out();
        reg0 = 4'hA; instr = 8'hE0; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || data_out !== 8'h0A || out_sel !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL out_single: valid=%b data=%h sel=%b count=%0d required 1 0a 0 1",
                     out_valid, data_out, out_sel, count);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL out_pop: valid=%b count=%0d required 0 0", out_valid, count);
        end
    endtask

    task automatic test_pair();
        reg0 = 4'h3; reg1 = 4'h5; instr = 8'hA0; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        reg1 = 4'hF;
        checks++;
        if (instr_ready !== 1'b0 || count !== 3'd1 || data_out !== 8'h03 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL pair_first: ready=%b count=%0d data=%h sel=%b required 0 1 03 0",
                     instr_ready, count, data_out, out_sel);
        end
        step();
        checks++;
        if (instr_ready !== 1'b1 || count !== 3'd2) begin
            errors++;
            $display("FAIL pair_second_push: ready=%b count=%0d required 1 2", instr_ready, count);
        end
        out_ready = 1'b1;
        checks++;
        if (data_out !== 8'h03 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL pair_beat0: data=%h sel=%b required 03 0", data_out, out_sel);
        end
        step();
        checks++;
        if (data_out !== 8'h05 || out_sel !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL pair_beat1: data=%h sel=%b count=%0d required 05 1 1",
                     data_out, out_sel, count);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair_drain: count=%0d valid=%b required 0 0", count, out_valid);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        instr = 8'hE1;
        for (int i = 1; i <= 4; i++) begin
            reg1 = 4'(i);
            instr_valid = 1'b1;
            step();
        end
        reg1 = 4'h5;
        checks++;
        if (count !== 3'd4 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_count: count=%0d ready=%b required 4 0", count, instr_ready);
        end
        step();
        checks++;
        if (count !== 3'd4 || data_out !== 8'h01 || out_sel !== 1'b1) begin
            errors++;
            $display("FAIL full_stall: count=%0d data=%h sel=%b required 4 01 1",
                     count, data_out, out_sel);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd3 || instr_ready !== 1'b1 || data_out !== 8'h02) begin
            errors++;
            $display("FAIL full_pop: count=%0d ready=%b data=%h required 3 1 02",
                     count, instr_ready, data_out);
        end
        step();
        instr_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL full_fifth: count=%0d required 4", count);
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (data_out !== 8'(k) || out_sel !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_order%0d: data=%h sel=%b valid=%b required %h 1 1",
                         k, data_out, out_sel, out_valid, 8'(k));
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL full_drain: count=%0d required 0", count);
        end
    endtask

    task automatic test_pair_full();
        logic [7:0] exp_data [4];
        logic       exp_sel  [4];
        exp_data[0] = 8'h07; exp_sel[0] = 1'b0;
        exp_data[1] = 8'h08; exp_sel[1] = 1'b0;
        exp_data[2] = 8'h09; exp_sel[2] = 1'b0;
        exp_data[3] = 8'h0C; exp_sel[3] = 1'b1;
        out_ready = 1'b0;
        instr = 8'hE0;
        for (int i = 6; i <= 8; i++) begin
            reg0 = 4'(i);
            instr_valid = 1'b1;
            step();
        end
        reg0 = 4'h9; reg1 = 4'hC; instr = 8'hA0;
        step();
        instr_valid = 1'b0;
        reg1 = 4'h1;
        step();
        step();
        checks++;
        if (count !== 3'd4 || instr_ready !== 1'b0 || data_out !== 8'h06) begin
            errors++;
            $display("FAIL pairfull_wait: count=%0d ready=%b data=%h required 4 0 06",
                     count, instr_ready, data_out);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL pairfull_swap: count=%0d required 4", count);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (data_out !== exp_data[k] || out_sel !== exp_sel[k]) begin
                errors++;
                $display("FAIL pairfull_order%0d: data=%h sel=%b required %h %b",
                         k, data_out, out_sel, exp_data[k], exp_sel[k]);
            end
            step();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL pairfull_drain: count=%0d ready=%b required 0 1", count, instr_ready);
        end
    endtask

    task automatic test_other_ops();
        logic [7:0] ops [3];
        ops[0] = 8'h01; ops[1] = 8'hC1; ops[2] = 8'h21;
        for (int k = 0; k < 3; k++) begin
            instr = ops[k];
            instr_valid = 1'b1;
            checks++;
            if (instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL other_ready%0d: ready=%b required 1", k, instr_ready);
            end
            step();
            instr_valid = 1'b0;
            checks++;
            if (count !== 3'd0 || out_valid !== 1'b0 || instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL other_nopush%0d: count=%0d valid=%b ready=%b required 0 0 1",
                         k, count, out_valid, instr_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        instr = 8'hE0; reg0 = 4'h2;
        instr_valid = 1'b1;
        step();
        step();
        instr = 8'hA0; reg0 = 4'h4; reg1 = 4'h6;
        step();
        instr_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: count=%0d ready=%b required 3 0", count, instr_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: valid=%b count=%0d ready=%b required 0 0 1",
                     out_valid, count, instr_ready);
        end
        step();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_stale: valid=%b count=%0d ready=%b required 0 0 1",
                     out_valid, count, instr_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_out();
        test_pair();
        test_full();
        test_pair_full();
        test_other_ops();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
